// File: rtl/bitonic_sorter_pkg.sv
// Shared types for the muon sorting chain: the muon candidate record.
package bitonic_sorter_pkg;

  // One muon candidate; the all-zero value is the empty (pad) muon.
  typedef struct packed {
    logic [9:0] pt;
    logic [5:0] quality;
  } muon_t;

endpackage

// File: rtl/muon_frame_packer_if.sv
// Handshake bundle for the frame packer: serial muon input side and
// parallel frame output side, plus the overrun flag.
interface muon_frame_packer_if #(
  parameter int WIDTH = 16
);
  import bitonic_sorter_pkg::*;

  logic                         s_valid;
  logic                         s_ready;
  muon_t                        s_muon;
  logic                         s_last;
  logic                         m_valid;
  logic                         m_ready;
  muon_t [0:WIDTH-1]            m_frame;
  logic [$clog2(WIDTH+1)-1:0]   m_count;
  logic                         err_overrun;

  // Environment side: produces muons, consumes frames.
  modport master (
    output s_valid, s_muon, s_last, m_ready,
    input  s_ready, m_valid, m_frame, m_count, err_overrun
  );

  // Packer side.
  modport slave (
    input  s_valid, s_muon, s_last, m_ready,
    output s_ready, m_valid, m_frame, m_count, err_overrun
  );

endinterface

// File: rtl/muon_frame_packer.sv
// Collects a serial stream of muons into WIDTH-wide frames for the bitonic
// sorter. Short events are zero-padded; events longer than WIDTH are cut at
// WIDTH, the excess muons are swallowed and err_overrun pulses once.
module muon_frame_packer #(
  parameter int WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  muon_frame_packer_if.slave bus
);
  import bitonic_sorter_pkg::*;

  localparam int IDX_W = $clog2(WIDTH);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_HOLD = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t               state_r;
  logic [IDX_W-1:0]     idx_r;
  muon_t [0:WIDTH-1]    asm_r;
  logic                 drop_pend_r;
  logic                 s_ready_r;
  logic                 m_valid_r;
  muon_t [0:WIDTH-1]    m_frame_r;
  logic [CNT_W-1:0]     m_count_r;
  logic                 err_r;

  logic                 accept_s;
  logic                 out_free_s;
  logic                 last_slot_s;
  logic                 close_s;
  logic                 overrun_s;
  muon_t [0:WIDTH-1]    asm_s;
  muon_t [0:WIDTH-1]    frame_s;

  // Handshake qualifiers and frame-closing conditions.
  always_comb begin
    accept_s    = bus.s_valid && s_ready_r;
    out_free_s  = !m_valid_r || bus.m_ready;
    last_slot_s = (idx_r == IDX_W'(WIDTH - 1));
    close_s     = accept_s && (state_r == ST_FILL) && (bus.s_last || last_slot_s);
    overrun_s   = close_s && last_slot_s && !bus.s_last;
  end

  // Padded frame image: buffer plus the muon arriving this cycle, slots past idx zeroed.
  // In HOLD the closing muon is already in the buffer and idx still points at it.
  always_comb begin
    asm_s   = asm_r;
    frame_s = '0;
    if ((state_r == ST_FILL) && accept_s) begin
      asm_s[idx_r] = bus.s_muon;
    end else begin
      asm_s[idx_r] = asm_r[idx_r];
    end
    for (int i = 0; i < WIDTH; i++) begin
      frame_s[i] = (IDX_W'(i) <= idx_r) ? asm_s[i] : muon_t'('0);
    end
  end

  // Fill/hold/drop controller with the output register and overrun flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_FILL;
      idx_r       <= '0;
      asm_r       <= '0;
      drop_pend_r <= 1'b0;
      s_ready_r   <= 1'b0;
      m_valid_r   <= 1'b0;
      m_frame_r   <= '0;
      m_count_r   <= '0;
      err_r       <= 1'b0;
    end else begin
      err_r <= overrun_s;
      // A retiring frame clears valid unless a load below overrides it.
      if (m_valid_r && bus.m_ready) begin
        m_valid_r <= 1'b0;
      end else begin
        m_valid_r <= m_valid_r;
      end
      case (state_r)
        ST_FILL: begin
          s_ready_r <= 1'b1;
          if (accept_s) begin
            asm_r[idx_r] <= bus.s_muon;
            if (close_s) begin
              drop_pend_r <= overrun_s;
              if (out_free_s) begin
                m_frame_r <= frame_s;
                m_count_r <= CNT_W'(idx_r) + CNT_W'(1);
                m_valid_r <= 1'b1;
                idx_r     <= '0;
                state_r   <= overrun_s ? ST_DROP : ST_FILL;
              end else begin
                state_r   <= ST_HOLD;
                s_ready_r <= 1'b0;
              end
            end else begin
              idx_r <= idx_r + IDX_W'(1);
            end
          end else begin
            idx_r <= idx_r;
          end
        end
        ST_HOLD: begin
          if (out_free_s) begin
            m_frame_r <= frame_s;
            m_count_r <= CNT_W'(idx_r) + CNT_W'(1);
            m_valid_r <= 1'b1;
            idx_r     <= '0;
            state_r   <= drop_pend_r ? ST_DROP : ST_FILL;
            s_ready_r <= 1'b1;
          end else begin
            s_ready_r <= 1'b0;
          end
        end
        ST_DROP: begin
          s_ready_r <= 1'b1;
          if (accept_s && bus.s_last) begin
            state_r <= ST_FILL;
          end else begin
            state_r <= ST_DROP;
          end
        end
        default: begin
          state_r   <= ST_FILL;
          idx_r     <= '0;
          s_ready_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.s_ready     = s_ready_r;
  assign bus.m_valid     = m_valid_r;
  assign bus.m_frame     = m_frame_r;
  assign bus.m_count     = m_count_r;
  assign bus.err_overrun = err_r;

endmodule

// File: tb/tb_muon_frame_packer.sv
// Self-checking bench for muon_frame_packer (WIDTH=4): directed scenarios
// with literal expectations plus a randomized run against a queue model.
module tb_muon_frame_packer;
  import bitonic_sorter_pkg::*;

  localparam int W  = 4;
  localparam int CW = $clog2(W + 1);
  typedef muon_t [0:W-1] frame_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  muon_frame_packer_if #(.WIDTH(W)) bus();

  muon_frame_packer #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state: muons of the open event, drop mode, expectations.
  muon_t   mdl_buf[$];
  bit      mdl_drop = 1'b0;
  frame_t  exp_frames[$];
  int      exp_counts[$];
  int      exp_err = 0;
  frame_t  obs_frames[$];
  int      obs_counts[$];
  int      obs_err = 0;
  bit      last_acc = 1'b0;

  function automatic frame_t mk(input logic [15:0] a, input logic [15:0] b,
                                input logic [15:0] c, input logic [15:0] d);
    frame_t f;
    f[0] = muon_t'(a);
    f[1] = muon_t'(b);
    f[2] = muon_t'(c);
    f[3] = muon_t'(d);
    return f;
  endfunction

  // One clock: sample handshakes before the edge, update the model after it.
  task automatic cyc();
    logic acc, ret, lst, rs;
    muon_t mu;
    frame_t fr;
    logic [CW-1:0] cnt;
    frame_t nf;
    acc = bus.s_valid && bus.s_ready;
    ret = bus.m_valid && bus.m_ready;
    lst = bus.s_last;
    mu  = bus.s_muon;
    fr  = bus.m_frame;
    cnt = bus.m_count;
    rs  = rst_n;
    @(posedge clk);
    #1;
    if (bus.err_overrun === 1'b1) obs_err++;
    last_acc = acc && rs;
    if (!rs) begin
      mdl_buf.delete();
      mdl_drop = 1'b0;
    end else begin
      if (ret) begin
        obs_frames.push_back(fr);
        obs_counts.push_back(int'(cnt));
      end
      if (acc) begin
        if (mdl_drop) begin
          if (lst) mdl_drop = 1'b0;
        end else begin
          mdl_buf.push_back(mu);
          if (lst || mdl_buf.size() == W) begin
            nf = '0;
            for (int i = 0; i < mdl_buf.size(); i++) nf[i] = mdl_buf[i];
            exp_frames.push_back(nf);
            exp_counts.push_back(mdl_buf.size());
            if (!lst) begin
              mdl_drop = 1'b1;
              exp_err++;
            end
            mdl_buf.delete();
          end
        end
      end
    end
  endtask

  task automatic send(input logic [15:0] v, input logic l);
    bus.s_valid = 1'b1;
    bus.s_muon  = muon_t'(v);
    bus.s_last  = l;
    cyc();
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc();
    cyc();
    checks++; if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid got=%b exp=0", bus.m_valid); end
    checks++; if (bus.m_frame !== frame_t'('0)) begin failures++; $display("FAIL reset_m_frame got=%h exp=0", bus.m_frame); end
    checks++; if (bus.m_count !== CW'(0)) begin failures++; $display("FAIL reset_m_count got=%0d exp=0", bus.m_count); end
    checks++; if (bus.err_overrun !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", bus.err_overrun); end
    checks++; if (bus.s_ready !== 1'b0) begin failures++; $display("FAIL reset_s_ready got=%b exp=0", bus.s_ready); end
    rst_n = 1'b1;
    cyc();
    checks++; if (bus.s_ready !== 1'b1) begin failures++; $display("FAIL post_reset_s_ready got=%b exp=1", bus.s_ready); end
  endtask

  task automatic test_full_frame();
    bus.m_ready = 1'b1;
    send(16'h11, 1'b0);
    send(16'h22, 1'b0);
    send(16'h33, 1'b0);
    checks++; if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL full_early_valid got=%b exp=0", bus.m_valid); end
    send(16'h44, 1'b1);
    checks++; if (bus.m_valid !== 1'b1) begin failures++; $display("FAIL full_valid got=%b exp=1", bus.m_valid); end
    checks++; if (bus.m_frame !== mk(16'h11, 16'h22, 16'h33, 16'h44)) begin failures++; $display("FAIL full_frame got=%h exp=%h", bus.m_frame, mk(16'h11, 16'h22, 16'h33, 16'h44)); end
    checks++; if (bus.m_count !== CW'(4)) begin failures++; $display("FAIL full_count got=%0d exp=4", bus.m_count); end
    checks++; if (bus.err_overrun !== 1'b0) begin failures++; $display("FAIL full_err got=%b exp=0", bus.err_overrun); end
    cyc();
    checks++; if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL full_retire got=%b exp=0", bus.m_valid); end
  endtask

  task automatic test_short();
    send(16'h5, 1'b0);
    send(16'h6, 1'b1);
    checks++; if (bus.m_frame !== mk(16'h5, 16'h6, 16'h0, 16'h0)) begin failures++; $display("FAIL short_frame got=%h exp=%h", bus.m_frame, mk(16'h5, 16'h6, 16'h0, 16'h0)); end
    checks++; if (bus.m_count !== CW'(2)) begin failures++; $display("FAIL short_count got=%0d exp=2", bus.m_count); end
    cyc();
  endtask

  task automatic test_overrun();
    send(16'h1, 1'b0);
    send(16'h2, 1'b0);
    send(16'h3, 1'b0);
    send(16'h4, 1'b0);
    checks++; if (bus.m_frame !== mk(16'h1, 16'h2, 16'h3, 16'h4)) begin failures++; $display("FAIL ovr_frame got=%h exp=%h", bus.m_frame, mk(16'h1, 16'h2, 16'h3, 16'h4)); end
    checks++; if (bus.m_count !== CW'(4)) begin failures++; $display("FAIL ovr_count got=%0d exp=4", bus.m_count); end
    checks++; if (bus.err_overrun !== 1'b1) begin failures++; $display("FAIL ovr_err_pulse got=%b exp=1", bus.err_overrun); end
    send(16'h5, 1'b0);
    checks++; if (bus.err_overrun !== 1'b0) begin failures++; $display("FAIL ovr_err_width got=%b exp=0", bus.err_overrun); end
    checks++; if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL ovr_drop5 got=%b exp=0", bus.m_valid); end
    send(16'h6, 1'b1);
    checks++; if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL ovr_drop6 got=%b exp=0", bus.m_valid); end
    send(16'h7, 1'b1);
    checks++; if (bus.m_frame !== mk(16'h7, 16'h0, 16'h0, 16'h0)) begin failures++; $display("FAIL ovr_next_frame got=%h exp=%h", bus.m_frame, mk(16'h7, 16'h0, 16'h0, 16'h0)); end
    checks++; if (bus.m_count !== CW'(1)) begin failures++; $display("FAIL ovr_next_count got=%0d exp=1", bus.m_count); end
    checks++; if (bus.err_overrun !== 1'b0) begin failures++; $display("FAIL ovr_next_err got=%b exp=0", bus.err_overrun); end
    cyc();
  endtask

  task automatic test_backpressure();
    frame_t fa, fb;
    fa = mk(16'hA1, 16'hA2, 16'hA3, 16'hA4);
    fb = mk(16'hB1, 16'hB2, 16'hB3, 16'hB4);
    bus.m_ready = 1'b0;
    send(16'hA1, 1'b0);
    send(16'hA2, 1'b0);
    send(16'hA3, 1'b0);
    send(16'hA4, 1'b1);
    checks++; if (bus.m_valid !== 1'b1 || bus.m_frame !== fa) begin failures++; $display("FAIL bp_a_present got=%b/%h exp=1/%h", bus.m_valid, bus.m_frame, fa); end
    for (int i = 1; i <= 3; i++) begin
      send(16'(16'hB0 + i), 1'b0);
      checks++; if (bus.m_frame !== fa || bus.m_valid !== 1'b1) begin failures++; $display("FAIL bp_a_stable got=%h exp=%h", bus.m_frame, fa); end
    end
    send(16'hB4, 1'b1);
    checks++; if (bus.s_ready !== 1'b0) begin failures++; $display("FAIL bp_hold_s_ready got=%b exp=0", bus.s_ready); end
    cyc();
    checks++; if (bus.s_ready !== 1'b0 || bus.m_frame !== fa) begin failures++; $display("FAIL bp_hold_keep got=%b/%h exp=0/%h", bus.s_ready, bus.m_frame, fa); end
    bus.m_ready = 1'b1;
    cyc();
    bus.m_ready = 1'b0;
    checks++; if (bus.m_valid !== 1'b1) begin failures++; $display("FAIL bp_b_valid got=%b exp=1", bus.m_valid); end
    checks++; if (bus.m_frame !== fb) begin failures++; $display("FAIL bp_b_frame got=%h exp=%h", bus.m_frame, fb); end
    checks++; if (bus.m_count !== CW'(4)) begin failures++; $display("FAIL bp_b_count got=%0d exp=4", bus.m_count); end
    checks++; if (bus.s_ready !== 1'b1) begin failures++; $display("FAIL bp_s_ready_back got=%b exp=1", bus.s_ready); end
    cyc();
    checks++; if (bus.m_frame !== fb || bus.m_valid !== 1'b1) begin failures++; $display("FAIL bp_b_stable got=%h exp=%h", bus.m_frame, fb); end
    bus.m_ready = 1'b1;
    cyc();
    checks++; if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL bp_b_retire got=%b exp=0", bus.m_valid); end
  endtask

  task automatic test_streaming();
    logic [15:0] v;
    bus.m_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      v = 16'(16'h40 + i);
      send(v, (i % 4) == 3);
      bus.s_valid = 1'b1;
      checks++; if (bus.s_ready !== 1'b1) begin failures++; $display("FAIL stream_s_ready i=%0d got=%b exp=1", i, bus.s_ready); end
      checks++; if (bus.m_valid !== ((i % 4) == 3)) begin failures++; $display("FAIL stream_m_valid i=%0d got=%b exp=%b", i, bus.m_valid, (i % 4) == 3); end
      if ((i % 4) == 3) begin
        checks++;
        if (bus.m_frame !== mk(16'(v - 16'd3), 16'(v - 16'd2), 16'(v - 16'd1), v)) begin
          failures++; $display("FAIL stream_frame i=%0d got=%h exp=%h", i, bus.m_frame, mk(16'(v - 16'd3), 16'(v - 16'd2), 16'(v - 16'd1), v));
        end
      end
    end
    bus.s_valid = 1'b0;
    cyc();
  endtask

  task automatic test_reset_mid();
    send(16'h81, 1'b0);
    send(16'h82, 1'b0);
    rst_n = 1'b0;
    cyc();
    checks++; if (bus.m_valid !== 1'b0 || bus.m_count !== CW'(0) || bus.m_frame !== frame_t'('0)) begin failures++; $display("FAIL midrst_outputs got=%b/%0d/%h exp=0/0/0", bus.m_valid, bus.m_count, bus.m_frame); end
    checks++; if (bus.s_ready !== 1'b0 || bus.err_overrun !== 1'b0) begin failures++; $display("FAIL midrst_ctrl got=%b/%b exp=0/0", bus.s_ready, bus.err_overrun); end
    rst_n = 1'b1;
    cyc();
    send(16'h9, 1'b1);
    checks++; if (bus.m_frame !== mk(16'h9, 16'h0, 16'h0, 16'h0)) begin failures++; $display("FAIL midrst_frame got=%h exp=%h", bus.m_frame, mk(16'h9, 16'h0, 16'h0, 16'h0)); end
    checks++; if (bus.m_count !== CW'(1)) begin failures++; $display("FAIL midrst_count got=%0d exp=1", bus.m_count); end
    checks++; if (bus.err_overrun !== 1'b0) begin failures++; $display("FAIL midrst_err got=%b exp=0", bus.err_overrun); end
    cyc();
  endtask

  task automatic test_random();
    logic hold;
    frame_t held;
    logic [CW-1:0] held_cnt;
    int n;
    exp_frames.delete(); exp_counts.delete();
    obs_frames.delete(); obs_counts.delete();
    exp_err = 0; obs_err = 0;
    last_acc = 1'b0;
    for (int c = 0; c < 600; c++) begin
      bus.m_ready = ($urandom_range(0, 9) < 7);
      if (!bus.s_valid || last_acc) begin
        bus.s_valid = ($urandom_range(0, 3) != 0);
        bus.s_muon  = muon_t'(16'($urandom));
        bus.s_last  = ($urandom_range(0, 4) == 0);
      end
      hold     = bus.m_valid && !bus.m_ready;
      held     = bus.m_frame;
      held_cnt = bus.m_count;
      cyc();
      if (hold) begin
        checks++;
        if (bus.m_valid !== 1'b1 || bus.m_frame !== held || bus.m_count !== held_cnt) begin
          failures++; $display("FAIL rand_stall_stable c=%0d got=%h exp=%h", c, bus.m_frame, held);
        end
      end
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b1;
    for (int c = 0; c < 6; c++) cyc();
    checks++; if (obs_frames.size() != exp_frames.size()) begin failures++; $display("FAIL rand_frame_total got=%0d exp=%0d", obs_frames.size(), exp_frames.size()); end
    n = (obs_frames.size() < exp_frames.size()) ? obs_frames.size() : exp_frames.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (obs_frames[i] !== exp_frames[i] || obs_counts[i] != exp_counts[i]) begin
        failures++; $display("FAIL rand_frame #%0d got=%h/%0d exp=%h/%0d", i, obs_frames[i], obs_counts[i], exp_frames[i], exp_counts[i]);
      end
    end
    checks++; if (obs_err != exp_err) begin failures++; $display("FAIL rand_overrun_pulses got=%0d exp=%0d", obs_err, exp_err); end
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_muon  = muon_t'(16'h0);
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b1;
    test_reset();
    test_full_frame();
    test_short();
    test_overrun();
    test_backpressure();
    test_streaming();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
